a2d_serf: RTL

- Synthesizable SPI responder (serf) modelling the 8-channel, 12-bit A2D converter used on the DE0-Nano board.
- It answers the two-transaction conversion protocol that our A2D interface master issues:
  - command frame {2'b00, chnl[2:0], 11'h000};
  - the following frame returns {4'h0, result[11:0]} for the channel named in the previous frame.
- Channel values come from a port, so the block serves both as a bench model and as an on-chip loopback responder.

---
 rtl/a2d_pkg.sv | 22 ++
 rtl/a2d_serf_if.sv | 10 +
 rtl/a2d_serf_spi_edge_sync.sv | 28 ++
 rtl/a2d_serf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the DE0-Nano A2D SPI responder and its users.
// The command helper builds the legal conversion request for a channel.
package a2d_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int A2D_CMD_W  = 16;
    localparam int A2D_RES_W  = 12;
    localparam int A2D_NUM_CH = 8;
    localparam int A2D_CH_LSB = 11;

    function automatic logic [A2D_CMD_W-1:0] a2d_cmd(input logic [2:0] ch);
        logic [A2D_CMD_W-1:0] w;
        w = '0;
        w[A2D_CH_LSB +: 3] = ch;
        return w;
    endfunction

endpackage

// File: rtl/a2d_serf_if.sv
// SPI pin bundle between the A2D interface master and the serf.
interface a2d_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_serf_spi_edge_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous pin, producing
// the synchronised level and single-clk rise/fall pulses.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] sr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= {3{RST_VAL}};
        end else begin
            sr_reg <= {sr_reg[1:0], din};
        end
    end

    assign sync = sr_reg[1];
    assign rise =  sr_reg[1] & ~sr_reg[2];
    assign fall = ~sr_reg[1] &  sr_reg[2];

endmodule

// File: rtl/a2d_serf.sv
// SPI responder modelling the DE0-Nano 8-channel 12-bit A2D: a command frame
// selects a channel, the following frame shifts that channel's value out.
module a2d_serf
    import a2d_pkg::*;
#(
    parameter logic [2:0] RST_CH   = 3'd0,
    parameter int         MIN_HALF = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    a2d_serf_if.slave                        spi,
    input  logic [A2D_NUM_CH*A2D_RES_W-1:0]  chnl_vals,
    output logic [A2D_CMD_W-1:0]             rx_cmd,
    output logic [2:0]                       cur_ch,
    output logic                             frm_done,
    output logic                             frm_err
);

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;
    localparam logic [7:0] HALF_MIN = 8'(MIN_HALF - 1);

    // Index 0 = SS_n, index 1 = SCLK
    logic [1:0] pin_in, pin_sync, pin_rise, pin_fall;
    logic ss_sync, ss_rise, ss_fall, sclk_sync, sclk_rise, sclk_fall;
    logic mosi_meta_reg, mosi_sync_reg;

    assign pin_in = {spi.SCLK, spi.SS_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        spi_edge_sync #(.RST_VAL(1'b1)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (pin_in[gi]),
            .sync (pin_sync[gi]),
            .rise (pin_rise[gi]),
            .fall (pin_fall[gi])
        );
    end

    assign ss_sync   = pin_sync[0];
    assign ss_rise   = pin_rise[0];
    assign ss_fall   = pin_fall[0];
    assign sclk_sync = pin_sync[1];
    assign sclk_rise = pin_rise[1];
    assign sclk_fall = pin_fall[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            mosi_meta_reg <= spi.MOSI;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

    logic [A2D_RES_W-1:0] ch_val [A2D_NUM_CH];

    for (genvar gi = 0; gi < A2D_NUM_CH; gi++) begin : g_ch
        assign ch_val[gi] = chnl_vals[gi*A2D_RES_W +: A2D_RES_W];
    end

    // A select already low when reset releases must not start a frame: wait
    // until the synchronised pin has really been seen high.
    logic [1:0] settle_reg;
    logic       armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_reg <= 2'd0;
            armed_reg  <= 1'b0;
        end else begin
            if (settle_reg != 2'd2) settle_reg <= settle_reg + 2'd1;
            if (settle_reg == 2'd2 && ss_sync) armed_reg <= 1'b1;
        end
    end

    state_t               state_reg, state_next;
    logic [A2D_CMD_W-1:0] tx_shft_reg, rx_shft_reg, rx_cmd_reg;
    logic [4:0]           bit_cnt_reg;
    logic                 seen_rise_reg;
    logic [2:0]           cur_ch_reg;
    logic                 frm_done_reg, frm_err_reg;
    logic                 start, shift_in, shift_out, done_set, err_set;
    logic                 cmd_legal;

    assign cmd_legal = (rx_shft_reg == a2d_cmd(rx_shft_reg[A2D_CH_LSB +: 3]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall && armed_reg) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Frame end wins over any SCLK edge in the same clk
                if (ss_rise) begin
                    state_next = IDLE;
                    if (bit_cnt_reg == CNT_FULL && cmd_legal) done_set = 1'b1;
                    else                                      err_set  = 1'b1;
                end else begin
                    shift_in  = sclk_rise;
                    shift_out = sclk_fall && seen_rise_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_reg   <= '0;
            rx_shft_reg   <= '0;
            bit_cnt_reg   <= 5'd0;
            seen_rise_reg <= 1'b0;
            rx_cmd_reg    <= '0;
            cur_ch_reg    <= RST_CH;
            frm_done_reg  <= 1'b0;
            frm_err_reg   <= 1'b0;
        end else begin
            frm_done_reg <= done_set;
            frm_err_reg  <= err_set;
            if (start) begin
                tx_shft_reg   <= {{(A2D_CMD_W-A2D_RES_W){1'b0}}, ch_val[cur_ch_reg]};
                rx_shft_reg   <= '0;
                bit_cnt_reg   <= 5'd0;
                seen_rise_reg <= 1'b0;
            end
            if (shift_in) begin
                rx_shft_reg   <= {rx_shft_reg[A2D_CMD_W-2:0], mosi_sync_reg};
                seen_rise_reg <= 1'b1;
                if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            if (shift_out) begin
                tx_shft_reg <= {tx_shft_reg[A2D_CMD_W-2:0], 1'b0};
            end
            if (done_set) begin
                rx_cmd_reg <= rx_shft_reg;
                cur_ch_reg <= rx_shft_reg[A2D_CH_LSB +: 3];
            end
        end
    end

    assign spi.MISO = ~ss_sync & tx_shft_reg[A2D_CMD_W-1];
    assign rx_cmd   = rx_cmd_reg;
    assign cur_ch   = cur_ch_reg;
    assign frm_done = frm_done_reg;
    assign frm_err  = frm_err_reg;

    // Master timing checks: SCLK half-period and SCLK parked high at deselect
    logic [7:0] half_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      half_cnt_reg <= 8'hFF;
        else if (sclk_rise || sclk_fall) half_cnt_reg <= 8'h00;
        else if (half_cnt_reg != 8'hFF)  half_cnt_reg <= half_cnt_reg + 8'd1;
    end

    a_sclk_half: assert property (@(posedge clk) disable iff (!rst_n)
        (sclk_rise || sclk_fall) |-> (half_cnt_reg >= HALF_MIN));

    a_sclk_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (ss_rise && state_reg == SHIFT) |-> sclk_sync);

endmodule
